// File: rtl/net_loader.sv
// net_loader: host-side frame loader for net_proc.
// Sync byte, input bytes, clear/load/start, then one result byte.
module net_loader #(
  parameter int          NUM_INPUTS     = 784,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE,
  parameter int          TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       net_start,
  input  logic       net_done,
  input  logic [3:0] net_max_idx,
  output logic       net_mem_rst,
  output logic       net_mem_we,
  output logic [7:0] net_mem_wdata
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FLUSH,
    S_START,
    S_SETTLE,
    S_RUN,
    S_REPORT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          mrst_q, mrst_d;
  logic          start_q, start_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          ovalid_q, ovalid_d;
  logic [7:0]    odata_q, odata_d;
  logic          acc;

  assign in_ready      = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy          = (state_q != S_IDLE);
  assign acc           = in_valid && in_ready;
  assign out_valid     = ovalid_q;
  assign out_data      = odata_q;
  assign net_start     = start_q;
  assign net_mem_rst   = mrst_q;
  assign net_mem_we    = we_q;
  assign net_mem_wdata = wdata_q;

  // Next-state and registered-output decode; pulses default low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    mrst_d   = 1'b0;
    start_d  = 1'b0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    case (state_q)
      S_IDLE: begin
        if (acc && (in_data == SYNC_BYTE)) begin
          state_d = S_CLEAR;
          mrst_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        wdog_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (acc) begin
          we_d    = 1'b1;
          wdata_d = in_data;
          cnt_d   = cnt_q + CW'(1);
          wdog_d  = '0;
          if (cnt_q == LAST) state_d = S_FLUSH;
        end else if (wdog_q == WMAX) begin
          ovalid_d = 1'b1;
          odata_d  = ERR_BYTE;
          state_d  = S_REPORT;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_FLUSH: begin
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (net_done) begin
          ovalid_d = 1'b1;
          odata_d  = {4'h0, net_max_idx};
          state_d  = S_REPORT;
        end else if (wdog_q == WMAX) begin
          ovalid_d = 1'b1;
          odata_d  = ERR_BYTE;
          state_d  = S_REPORT;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_REPORT: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wdog_q   <= '0;
      mrst_q   <= 1'b0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      mrst_q   <= mrst_d;
      start_q  <= start_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

endmodule

// File: tb/tb_net_loader.sv
// tb_net_loader: scoreboard bench for net_loader.
// Two instances: default watchdog and a 64-cycle watchdog.
module tb_net_loader;

  localparam int N = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       net_done = 1'b0;
  logic [3:0] net_max_idx = 4'h0;
  logic       sel = 1'b0;

  logic       a_ir, a_ov, a_busy, a_st, a_mr, a_we;
  logic [7:0] a_od, a_wd;
  logic       b_ir, b_ov, b_busy, b_st, b_mr, b_we;
  logic [7:0] b_od, b_wd;

  logic       in_ready, out_valid, busy, net_start, net_mem_rst, net_mem_we;
  logic [7:0] out_data, net_mem_wdata;

  net_loader dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .busy(a_busy), .net_start(a_st), .net_done(net_done),
    .net_max_idx(net_max_idx), .net_mem_rst(a_mr),
    .net_mem_we(a_we), .net_mem_wdata(a_wd)
  );

  net_loader #(.TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .busy(b_busy), .net_start(b_st), .net_done(net_done),
    .net_max_idx(net_max_idx), .net_mem_rst(b_mr),
    .net_mem_we(b_we), .net_mem_wdata(b_wd)
  );

  // Route the selected instance to the shared observation signals.
  always_comb begin
    in_ready      = sel ? b_ir   : a_ir;
    out_valid     = sel ? b_ov   : a_ov;
    out_data      = sel ? b_od   : a_od;
    busy          = sel ? b_busy : a_busy;
    net_start     = sel ? b_st   : a_st;
    net_mem_rst   = sel ? b_mr   : a_mr;
    net_mem_we    = sel ? b_we   : a_we;
    net_mem_wdata = sel ? b_wd   : a_wd;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // net_proc stand-in: done is a level cleared one cycle after start.
  int         mdelay = 100;
  logic [3:0] midx = 4'h7;
  bit         mnever = 1'b0;
  int         mcnt = 0;
  bit         mclr = 1'b0;

  always @(posedge clk) begin
    if (mclr) begin
      net_done <= 1'b0;
      mclr     <= 1'b0;
    end
    if (net_start) begin
      mclr <= 1'b1;
      mcnt <= mdelay;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !mnever) begin
        net_done    <= 1'b1;
        net_max_idx <= midx;
      end
    end
  end

  int         exp_rst_q[$];
  int         exp_w_cyc[$];
  logic [7:0] exp_w_dat[$];
  int         exp_st_q[$];
  logic [7:0] exp_res_q[$];

  bit         prev_ov = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_od = 8'h00;
  int         rise_cyc = 0;

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (net_mem_rst) begin
        if (exp_rst_q.size() == 0) chk("mem_rst_unexpected", 1, 0);
        else chk("mem_rst_cyc", cyc, exp_rst_q.pop_front());
      end
      if (net_mem_we) begin
        if (exp_w_cyc.size() == 0) chk("we_unexpected", 1, 0);
        else begin
          chk("we_cyc", cyc, exp_w_cyc.pop_front());
          chk("we_data", net_mem_wdata, exp_w_dat.pop_front());
        end
      end
      if (net_start) begin
        chk("start_with_we", net_mem_we, 0);
        if (exp_st_q.size() == 0) chk("start_unexpected", 1, 0);
        else chk("start_cyc", cyc, exp_st_q.pop_front());
      end
      if (prev_hold) begin
        chk("out_valid_held", out_valid, 1);
        chk("out_data_held", out_data, prev_od);
      end
      if (out_valid) begin
        if (!prev_ov) rise_cyc = cyc;
        chk("in_ready_in_report", in_ready, 0);
        if (out_ready) begin
          if (exp_res_q.size() == 0) chk("result_unexpected", 1, 0);
          else chk("result", out_data, exp_res_q.pop_front());
        end
      end
      prev_ov   = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_od   = out_data;
    end
  end

  logic [7:0] fd[N];
  int         last_acc = 0;

  // kind: 0 dropped, 1 sync, 2 data, 3 last data.
  task automatic send(input logic [7:0] b, input int gap, input int kind);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (kind == 0) chk("garbage_ready", n, 0);
    last_acc = cyc;
    if (kind == 1) exp_rst_q.push_back(cyc + 1);
    if (kind >= 2) begin
      exp_w_cyc.push_back(cyc + 1);
      exp_w_dat.push_back(b);
    end
    if (kind == 3) exp_st_q.push_back(cyc + 2);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n;
    n = 0;
    while (exp_res_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_res_q.size() != 0) begin
      chk("result_timeout", exp_res_q.size(), 0);
      exp_res_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("idle_after_report", busy, 0);
  endtask

  task automatic run_frame(input int maxgap, input logic [7:0] res,
                           input int hold, input bit tmo);
    int n;
    int la;
    if (hold > 0) begin
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end
    send(8'hA5, 0, 1);
    for (int i = 0; i < N; i++)
      send(fd[i], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0,
           (i == N - 1) ? 3 : 2);
    la = last_acc;
    exp_res_q.push_back(res);
    if (hold > 0) begin
      n = 0;
      while (!out_valid && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) chk("report_wait", 0, 1);
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    wait_res(3000);
    if (tmo) chk("run_timeout_cyc", rise_cyc, la + 68);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) fd[i] = 8'($urandom);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int la;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_start", net_start, 0);
    chk("rst_mem_rst", net_mem_rst, 0);
    chk("rst_mem_we", net_mem_we, 0);
    chk("rst_wdata", net_mem_wdata, 0);

    // Nominal ramp frame.
    for (int i = 0; i < N; i++) fd[i] = 8'(i % 256);
    mdelay = 100;
    midx = 4'h7;
    run_frame(0, 8'h07, 0, 1'b0);

    // Garbage before sync is dropped.
    send(8'h00, 0, 0);
    send(8'h5A, 0, 0);
    send(8'hFF, 2, 0);
    rand_frame();
    midx = 4'h4;
    run_frame(0, 8'h04, 0, 1'b0);

    // Input gaps and result back-pressure.
    rand_frame();
    midx = 4'hC;
    mdelay = 30;
    run_frame(3, 8'h0C, 20, 1'b0);

    // Stale done from previous run must not leak.
    rand_frame();
    midx = 4'h3;
    run_frame(1, 8'h03, 0, 1'b0);
    rand_frame();
    midx = 4'h9;
    mdelay = 50;
    run_frame(0, 8'h09, 0, 1'b0);

    // Reset in the middle of a frame.
    send(8'hA5, 0, 1);
    for (int i = 0; i < 300; i++) send(8'($urandom), 0, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_start", net_start, 0);
    chk("mid_rst_mem_rst", net_mem_rst, 0);
    chk("mid_rst_mem_we", net_mem_we, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    rand_frame();
    midx = 4'h5;
    mdelay = 40;
    run_frame(0, 8'h05, 0, 1'b0);

    // Short watchdog instance: run timeout, then load stall.
    @(posedge clk);
    #1 rst = 1'b1;
    sel = 1'b1;
    do_reset();
    mnever = 1'b1;
    rand_frame();
    run_frame(0, 8'hEE, 0, 1'b1);

    send(8'hA5, 0, 1);
    for (int i = 0; i < 10; i++) send(8'($urandom), 0, 2);
    la = last_acc;
    exp_res_q.push_back(8'hEE);
    wait_res(500);
    chk("load_timeout_cyc", rise_cyc, la + 65);
    chk("load_timeout_in_ready", in_ready, 1);

    repeat (4) @(negedge clk);
    chk("left_mem_rst", exp_rst_q.size(), 0);
    chk("left_writes", exp_w_cyc.size(), 0);
    chk("left_starts", exp_st_q.size(), 0);
    chk("left_results", exp_res_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
